// File: rtl/immediate_pipe_if.sv
// Fetch-to-decode immediate pipe bus: input handshake with instruction/PC/format select,
// and output handshake carrying the extended immediate, PC+IMM target and format used.
interface immediate_pipe_if #(
  parameter int XLEN = 64
);
  logic            IN_VALID;
  logic            IN_READY;
  logic [31:0]     INSTRUCTION;
  logic [XLEN-1:0] PC;
  logic [2:0]      SELECTION;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] IMM;
  logic [XLEN-1:0] TARGET;
  logic [2:0]      FORMAT;

  // Producer/consumer environment side
  modport master (
    output IN_VALID, INSTRUCTION, PC, SELECTION, OUT_READY,
    input  IN_READY, OUT_VALID, IMM, TARGET, FORMAT
  );

  // Immediate pipe side
  modport slave (
    input  IN_VALID, INSTRUCTION, PC, SELECTION, OUT_READY,
    output IN_READY, OUT_VALID, IMM, TARGET, FORMAT
  );
endinterface

// File: rtl/immediate_pipe.sv
// Registered immediate extractor with PC+IMM precompute and a main+skid buffer.
// Optional IMMEDIATE_PIPE_ZIMM_EN adds format 6 (zero-extended CSR uimm inst[19:15]).
module immediate_pipe #(
  parameter int XLEN        = 64,
  parameter bit AUTO_DECODE = 1'b1
) (
  input logic              CLK,
  input logic              RESET_N,
  input logic              FLUSH,
  immediate_pipe_if.slave  bus
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_U    = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  function automatic logic [2:0] decode_fmt(input logic [31:0] inst, input logic [2:0] sel);
    logic [2:0] f;
    f = FMT_NONE;
    if (AUTO_DECODE) begin
      case (inst[6:0])
        7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: f = FMT_I;
        7'b1110011: begin
`ifdef IMMEDIATE_PIPE_ZIMM_EN
          // funct3[2] marks the CSR immediate forms
          if (inst[14]) begin
            f = FMT_Z;
          end else begin
            f = FMT_I;
          end
`else
          f = FMT_I;
`endif
        end
        7'b0110111, 7'b0010111: f = FMT_U;
        7'b0100011:             f = FMT_S;
        7'b1100011:             f = FMT_B;
        7'b1101111:             f = FMT_J;
        default:                f = FMT_NONE;
      endcase
    end else begin
      case (sel)
        FMT_I, FMT_U, FMT_S, FMT_B, FMT_J: f = sel;
`ifdef IMMEDIATE_PIPE_ZIMM_EN
        FMT_Z:                             f = FMT_Z;
`endif
        default:                           f = FMT_NONE;
      endcase
    end
    return f;
  endfunction

  // All forms fit in 32 signed bits; the size cast sign-extends to XLEN.
  function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] inst, input logic [2:0] fmt);
    logic signed [31:0] t;
    t = 32'sd0;
    case (fmt)
      FMT_I: t = {{20{inst[31]}}, inst[31:20]};
      FMT_U: t = {inst[31:12], 12'h000};
      FMT_S: t = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: t = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_J: t = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`ifdef IMMEDIATE_PIPE_ZIMM_EN
      FMT_Z: t = {27'd0, inst[19:15]};
`endif
      default: t = 32'sd0;
    endcase
    return XLEN'(t);
  endfunction

  logic            m_valid_r;
  logic            s_valid_r;
  logic            in_ready_r;
  logic [2:0]      m_fmt_r;
  logic [XLEN-1:0] m_imm_r;
  logic [XLEN-1:0] m_tgt_r;
  logic [2:0]      s_fmt_r;
  logic [XLEN-1:0] s_imm_r;
  logic [XLEN-1:0] s_tgt_r;

  logic [2:0]      in_fmt_s;
  logic [XLEN-1:0] in_imm_s;
  logic [XLEN-1:0] in_tgt_s;
  logic            accept_s;
  logic            m_free_s;
  logic            m_load_in_s;
  logic            m_load_skid_s;
  logic            s_load_s;
  logic            m_valid_nxt_s;
  logic            s_valid_nxt_s;

  // Input-side extraction and target adder
  always_comb begin
    in_fmt_s = decode_fmt(bus.INSTRUCTION, bus.SELECTION);
    in_imm_s = ext_imm(bus.INSTRUCTION, in_fmt_s);
    in_tgt_s = bus.PC + in_imm_s;
  end

  // Main/skid steering: M refills from S first to keep FIFO order
  always_comb begin
    accept_s      = bus.IN_VALID & in_ready_r;
    m_free_s      = ~m_valid_r | bus.OUT_READY;
    m_load_in_s   = 1'b0;
    m_load_skid_s = 1'b0;
    s_load_s      = 1'b0;
    m_valid_nxt_s = 1'b0;
    s_valid_nxt_s = 1'b0;
    if (m_free_s) begin
      if (s_valid_r) begin
        m_load_skid_s = 1'b1;
        m_valid_nxt_s = 1'b1;
        s_load_s      = accept_s;
        s_valid_nxt_s = accept_s;
      end else if (accept_s) begin
        m_load_in_s   = 1'b1;
        m_valid_nxt_s = 1'b1;
      end else begin
        m_valid_nxt_s = 1'b0;
      end
    end else begin
      m_valid_nxt_s = 1'b1;
      if (accept_s) begin
        s_load_s      = 1'b1;
        s_valid_nxt_s = 1'b1;
      end else begin
        s_valid_nxt_s = s_valid_r;
      end
    end
  end

  // Occupancy flags and registered IN_READY; FLUSH empties both entries
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      in_ready_r <= 1'b1;
    end else if (FLUSH) begin
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      m_valid_r  <= m_valid_nxt_s;
      s_valid_r  <= s_valid_nxt_s;
      in_ready_r <= ~s_valid_nxt_s;
    end
  end

  // Payload registers load only when an entry is filled
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_fmt_r <= 3'd0;
      m_imm_r <= '0;
      m_tgt_r <= '0;
      s_fmt_r <= 3'd0;
      s_imm_r <= '0;
      s_tgt_r <= '0;
    end else if (!FLUSH) begin
      if (m_load_skid_s) begin
        m_fmt_r <= s_fmt_r;
        m_imm_r <= s_imm_r;
        m_tgt_r <= s_tgt_r;
      end else if (m_load_in_s) begin
        m_fmt_r <= in_fmt_s;
        m_imm_r <= in_imm_s;
        m_tgt_r <= in_tgt_s;
      end
      if (s_load_s) begin
        s_fmt_r <= in_fmt_s;
        s_imm_r <= in_imm_s;
        s_tgt_r <= in_tgt_s;
      end
    end
  end

  assign bus.IN_READY  = in_ready_r;
  assign bus.OUT_VALID = m_valid_r;
  assign bus.IMM       = m_imm_r;
  assign bus.TARGET    = m_tgt_r;
  assign bus.FORMAT    = m_fmt_r;

endmodule

// File: doc/immediate_pipe.md
Name: immediate_pipe

Overview:
Registered, parametrised successor to the combinational immediate extractor. Sits between fetch and decode/execute:
- accepts an instruction and its PC over a valid/ready handshake;
- produces the sign-extended immediate at XLEN width, optionally auto-selecting the format from the opcode;
- precomputes PC+IMM for branch/JAL/AUIPC.
A two-entry (main + skid) buffer gives full throughput with a registered IN_READY.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64; immediates sign-extended to XLEN.
AUTO_DECODE, 1, 1 = format derived from opcode; 0 = format taken from SELECTION input.

Ports:
CLK  input  1  clock, rising edge.
RESET_N  input  1  asynchronous active-low reset.
FLUSH  input  1  synchronous pipeline kill; discards buffered entries.
IN_VALID  input  1  INSTRUCTION/PC/SELECTION valid.
IN_READY  output  1  block can accept; registered.
INSTRUCTION  input  32  raw RV instruction word.
PC  input  XLEN  address of INSTRUCTION.
SELECTION  input  3  format code (1=I, 2=U, 3=S, 4=B, 5=J); ignored when AUTO_DECODE=1.
OUT_VALID  output  1  IMM/TARGET/FORMAT valid.
OUT_READY  input  1  consumer accepts.
IMM  output  XLEN  signed immediate.
TARGET  output  XLEN  PC+IMM, modulo 2^XLEN.
FORMAT  output  3  format code used (0 = none).

Behaviour:
- Reset (RESET_N low, asynchronous): both entries invalid; OUT_VALID=0, IN_READY=1, IMM=0, TARGET=0, FORMAT=0. Reset mid-transfer drops all data.
- Format codes: 1=I, 2=U, 3=S, 4=B, 5=J. With AUTO_DECODE=0, any other SELECTION value gives format 0.
- Auto-decode on opcode INSTRUCTION[6:0]:
  - 0000011, 0010011, 0011011, 1100111, 1110011 -> I.
  - 0110111, 0010111 -> U.
  - 0100011 -> S.
  - 1100011 -> B.
  - 1101111 -> J.
  - Anything else -> 0.
- Immediate forms, each sign-extended from the MSB shown to XLEN:
  - I: inst[31:20].
  - U: {inst[31:12], 12'h0}.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Format 0: IMM = 0.
- TARGET = PC + IMM, truncated to XLEN, computed for every format (consumer decides use).
- Latency: 1 cycle from accepted input to OUT_VALID when the output is empty or draining.
- Handshake:
  - Transfer in when IN_VALID & IN_READY; transfer out when OUT_VALID & OUT_READY.
  - Output payload is held stable while OUT_VALID=1 and OUT_READY=0.
- Buffer: main entry M drives the outputs; skid entry S.
  - M empty, or M transferring out: M <= S if S valid (S emptied), else the accepted input, else empty.
  - M valid and not transferring out, with an accepted input: input goes to S.
  - IN_READY next cycle = ~S_valid_next, so IN_READY drops only once S is occupied.
  - Simultaneous in/out with S valid: S moves to M; the new input lands in S. IN_READY was 0 in that case, so no input is actually accepted.
- Ordering: strict FIFO, no reordering, no drops except on flush.
- FLUSH (sync, highest priority after reset): M and S invalidated next edge. An input presented in the same cycle is discarded even if IN_READY=1. IN_READY=1 the following cycle. Payload registers may retain stale values, but OUT_VALID=0.
- Registered payload is latched only on load, which saves toggling.

Optional Feature:
Macro IMMEDIATE_PIPE_ZIMM_EN.
- Defined: adds format 6 = Z, zero-extended CSR immediate inst[19:15].
  - Auto-decode: opcode 1110011 with funct3[2]=1 -> Z (overrides I).
  - Manual mode: SELECTION=6 selects Z.
  - TARGET is still PC+IMM.
- Undefined: SELECTION 6 and 7 give format 0 and IMM 0; opcode 1110011 always decodes as I.

Test Plan:
- Reset then idle: RESET_N low mid-stream with OUT_VALID=1 -> next sampled OUT_VALID=0, IN_READY=1, IMM=0, TARGET=0.
- XLEN=64, AUTO_DECODE=1, INSTRUCTION=0xFFF00093 (addi -1), PC=0x1000 -> one cycle later FORMAT=1, IMM=0xFFFFFFFFFFFFFFFF, TARGET=0xFFF.
- INSTRUCTION=0xFE000EE3 (beq -4), PC=0x2000 -> FORMAT=4, IMM=-4, TARGET=0x1FFC. INSTRUCTION=0x0080006F (jal +8), PC=0x2000 -> FORMAT=5, TARGET=0x2008. INSTRUCTION=0x12345037 (lui) -> FORMAT=2, IMM=0x12345000.
- Backpressure: stream 4 back-to-back instructions with OUT_READY=0 -> the first two are accepted, IN_READY=0 from cycle 2; release OUT_READY -> all 4 emerge in order, none lost or duplicated; sustained 1/cycle thereafter.
- FLUSH with M and S both full plus IN_VALID=1 -> OUT_VALID=0 next cycle, IN_READY=1; the flushed instructions never appear.
- XLEN=32, AUTO_DECODE=0, SELECTION=3, INSTRUCTION=0xFE112E23 (sw, imm -4) -> IMM=0xFFFFFFFC. With IMMEDIATE_PIPE_ZIMM_EN, SELECTION=6, inst[19:15]=0x1F -> IMM=0x1F.
